// File: rtl/clk_rst_mon.sv
// Receive-side reset monitor: measures every completed pulse on each reset lane
// and streams one (lane, length) report per pulse through a valid/ready port.
//
// state  | meaning
// SYNC   | after monitor reset; waiting for the lane to be seen low
// IDLE   | lane low, armed for the next pulse
// ACTIVE | lane high, pulse length being counted
module clk_rst_mon #(
  parameter int FANOUT    = 4,
  parameter int MIN_PULSE = 4,
  parameter int CNT_W     = 16,
  parameter int LANE_W    = (FANOUT > 1) ? $clog2(FANOUT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FANOUT-1:0] rst_in,
  output logic [FANOUT-1:0] lane_active,
  output logic [FANOUT-1:0] err_short,
  output logic [FANOUT-1:0] err_ovf,
  input  logic              err_clr,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [LANE_W-1:0] rpt_lane,
  output logic [CNT_W-1:0]  rpt_len
);

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_IDLE   = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q [FANOUT];
  state_e            state_d [FANOUT];
  logic [CNT_W-1:0]  cnt_q   [FANOUT];
  logic [CNT_W-1:0]  cnt_d   [FANOUT];
  logic [CNT_W-1:0]  pend_len_q [FANOUT];
  logic [CNT_W-1:0]  pend_len_d [FANOUT];
  logic [FANOUT-1:0] pend_vld_q, pend_vld_d;
  logic [FANOUT-1:0] err_short_q, err_short_d;
  logic [FANOUT-1:0] err_ovf_q, err_ovf_d;
  logic [FANOUT-1:0] complete, short_set, ovf_set, grant;
  logic [LANE_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              rpt_valid_q, rpt_valid_d;
  logic [LANE_W-1:0] rpt_lane_q, rpt_lane_d;
  logic [CNT_W-1:0]  rpt_len_q, rpt_len_d;
  logic              out_free, found, load;
  logic [LANE_W-1:0] sel;
  logic [CNT_W-1:0]  sel_len;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FANOUT; i++) state_q[i] <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    for (int i = 0; i < FANOUT; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_SYNC:   if (!rst_in[i]) state_d[i] = S_IDLE;
        S_IDLE:   if (rst_in[i])  state_d[i] = S_ACTIVE;
        S_ACTIVE: if (!rst_in[i]) state_d[i] = S_IDLE;
        default:  state_d[i] = S_SYNC;
      endcase
    end
  end

  // Output decode
  always_comb begin
    for (int i = 0; i < FANOUT; i++) begin
      lane_active[i] = (state_q[i] == S_ACTIVE);
    end
  end

  // Pulse counters and completion detection
  always_comb begin
    for (int i = 0; i < FANOUT; i++) begin
      cnt_d[i]     = cnt_q[i];
      complete[i]  = 1'b0;
      short_set[i] = 1'b0;
      case (state_q[i])
        S_IDLE: begin
          if (rst_in[i]) cnt_d[i] = CNT_W'(1);
        end
        S_ACTIVE: begin
          if (rst_in[i]) begin
            if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end else begin
            complete[i]  = 1'b1;
            short_set[i] = (int'(cnt_q[i]) < MIN_PULSE);
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
  end

  // Round-robin pick among full pending slots, starting at rr_ptr_q
  always_comb begin
    int idx;
    found   = 1'b0;
    sel     = '0;
    sel_len = '0;
    idx     = 0;
    for (int j = 0; j < FANOUT; j++) begin
      idx = (int'(rr_ptr_q) + j) % FANOUT;
      if (!found && pend_vld_q[idx]) begin
        found   = 1'b1;
        sel     = LANE_W'(idx);
        sel_len = pend_len_q[idx];
      end
    end
  end

  assign out_free = !rpt_valid_q || rpt_ready;
  assign load     = out_free && found;

  always_comb begin
    for (int i = 0; i < FANOUT; i++) begin
      grant[i] = load && (sel == LANE_W'(i));
    end
  end

  // Pending slots: a slot granted this edge may take a new pulse without overflow
  always_comb begin
    pend_vld_d = pend_vld_q;
    ovf_set    = '0;
    for (int i = 0; i < FANOUT; i++) begin
      pend_len_d[i] = pend_len_q[i];
      if (grant[i]) pend_vld_d[i] = 1'b0;
      if (complete[i]) begin
        if (!pend_vld_q[i] || grant[i]) begin
          pend_vld_d[i] = 1'b1;
          pend_len_d[i] = cnt_q[i];
        end else begin
          ovf_set[i] = 1'b1;
        end
      end
    end
  end

  // Output register and arbitration pointer
  always_comb begin
    rpt_valid_d = rpt_valid_q;
    rpt_lane_d  = rpt_lane_q;
    rpt_len_d   = rpt_len_q;
    rr_ptr_d    = rr_ptr_q;
    if (out_free) rpt_valid_d = found;
    if (load) begin
      rpt_lane_d = sel;
      rpt_len_d  = sel_len;
      if (int'(sel) == FANOUT - 1) rr_ptr_d = '0;
      else                         rr_ptr_d = sel + LANE_W'(1);
    end
  end

  // Sticky errors: a set on the same edge as a clear wins
  always_comb begin
    err_short_d = (err_short_q & ~{FANOUT{err_clr}}) | short_set;
    err_ovf_d   = (err_ovf_q   & ~{FANOUT{err_clr}}) | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FANOUT; i++) begin
        cnt_q[i]      <= '0;
        pend_len_q[i] <= '0;
      end
      pend_vld_q  <= '0;
      err_short_q <= '0;
      err_ovf_q   <= '0;
      rr_ptr_q    <= '0;
      rpt_valid_q <= 1'b0;
      rpt_lane_q  <= '0;
      rpt_len_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pend_len_q  <= pend_len_d;
      pend_vld_q  <= pend_vld_d;
      err_short_q <= err_short_d;
      err_ovf_q   <= err_ovf_d;
      rr_ptr_q    <= rr_ptr_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_lane_q  <= rpt_lane_d;
      rpt_len_q   <= rpt_len_d;
    end
  end

  assign err_short = err_short_q;
  assign err_ovf   = err_ovf_q;
  assign rpt_valid = rpt_valid_q;
  assign rpt_lane  = rpt_lane_q;
  assign rpt_len   = rpt_len_q;

endmodule

// File: tb/tb_clk_rst_mon.sv
// Directed bench for clk_rst_mon: main instance with 16-bit counters plus a
// 4-bit counter instance for saturation.
module tb_clk_rst_mon;

  logic       clk;
  logic       rst;
  logic [3:0] rst_in;
  logic [3:0] lane_active, err_short, err_ovf;
  logic       err_clr;
  logic       rpt_valid, rpt_ready;
  logic [1:0] rpt_lane;
  logic [15:0] rpt_len;

  logic [3:0] rst_in4;
  logic [3:0] lane_active4, err_short4, err_ovf4;
  logic       rpt_valid4, rpt_ready4;
  logic [1:0] rpt_lane4;
  logic [3:0] rpt_len4;

  int checks   = 0;
  int failures = 0;

  clk_rst_mon #(.FANOUT(4), .MIN_PULSE(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rst_in(rst_in), .lane_active(lane_active),
    .err_short(err_short), .err_ovf(err_ovf), .err_clr(err_clr),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_lane(rpt_lane),
    .rpt_len(rpt_len)
  );

  clk_rst_mon #(.FANOUT(4), .MIN_PULSE(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .rst_in(rst_in4), .lane_active(lane_active4),
    .err_short(err_short4), .err_ovf(err_ovf4), .err_clr(err_clr),
    .rpt_valid(rpt_valid4), .rpt_ready(rpt_ready4), .rpt_lane(rpt_lane4),
    .rpt_len(rpt_len4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rpt(input string tag, input logic [31:0] v, input logic [31:0] l,
                         input logic [31:0] n);
    chk({tag, "_valid"}, {31'd0, rpt_valid}, v);
    chk({tag, "_lane"},  {30'd0, rpt_lane},  l);
    chk({tag, "_len"},   {16'd0, rpt_len},   n);
  endtask

  // Lanes 3,2,1,0 rise on successive edges and all fall together: lengths 8,7,6,5
  task automatic all_four();
    rst_in[3] = 1'b1; tick();
    rst_in[2] = 1'b1; tick();
    rst_in[1] = 1'b1; tick();
    rst_in[0] = 1'b1;
    repeat (5) tick();
    chk("all4_active", {28'd0, lane_active}, 32'hF);
    rst_in = 4'h0;
    tick();
    chk("all4_fall_active", {28'd0, lane_active}, 32'h0);
    chk("all4_fall_valid", {31'd0, rpt_valid}, 32'd0);
  endtask

  initial begin
    int lane_a[4] = '{0, 1, 2, 3};
    int len_a[4]  = '{5, 6, 7, 8};
    int lane_b[4] = '{2, 3, 0, 1};
    int len_b[4]  = '{7, 8, 5, 6};

    rst = 1'b1; rst_in = 4'h0; err_clr = 1'b0; rpt_ready = 1'b1;
    rst_in4 = 4'h0; rpt_ready4 = 1'b1;
    tick(); tick();
    chk("rst_active", {28'd0, lane_active}, 32'h0);
    chk("rst_short",  {28'd0, err_short},   32'h0);
    chk("rst_ovf",    {28'd0, err_ovf},     32'h0);
    chk_rpt("rst", 0, 0, 0);
    chk("rst_valid4", {31'd0, rpt_valid4}, 32'd0);
    rst = 1'b0;
    tick();

    // Simultaneous fall, pointer at 0
    all_four();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_rpt("rr0", 1, lane_a[i], len_a[i]);
    end
    tick();
    chk("rr0_drain", {31'd0, rpt_valid}, 32'd0);

    // Single 10-cycle pulse on lane 0
    rst_in[0] = 1'b1;
    tick();
    chk("p10_rise", {28'd0, lane_active}, 32'h1);
    repeat (9) tick();
    rst_in[0] = 1'b0;
    tick();
    chk("p10_fall_active", {28'd0, lane_active}, 32'h0);
    chk("p10_fall_valid", {31'd0, rpt_valid}, 32'd0);
    tick();
    chk_rpt("p10", 1, 0, 10);
    tick();
    chk("p10_accept", {31'd0, rpt_valid}, 32'd0);
    chk("p10_short", {28'd0, err_short}, 32'h0);
    chk("p10_ovf",   {28'd0, err_ovf},   32'h0);

    // Runt on lane 1, sticky then cleared
    rst_in[1] = 1'b1;
    repeat (2) tick();
    rst_in[1] = 1'b0;
    tick();
    chk("runt_short", {28'd0, err_short}, 32'h2);
    tick();
    chk_rpt("runt", 1, 1, 2);
    tick();
    chk("runt_sticky", {28'd0, err_short}, 32'h2);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("runt_clr", {28'd0, err_short}, 32'h0);

    // Runt completing on the same edge as err_clr: set wins
    rst_in[1] = 1'b1;
    repeat (2) tick();
    rst_in[1] = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("runt_clr_win", {28'd0, err_short}, 32'h2);
    tick();
    chk_rpt("runt2", 1, 1, 2);
    tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("runt2_clr", {28'd0, err_short}, 32'h0);

    // Simultaneous fall with pointer after lane 1
    all_four();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_rpt("rr2", 1, lane_b[i], len_b[i]);
    end
    tick();
    chk("rr2_drain", {31'd0, rpt_valid}, 32'd0);

    // Saturation on the 4-bit instance
    rst_in4[0] = 1'b1;
    repeat (20) tick();
    rst_in4[0] = 1'b0;
    tick(); tick();
    chk("sat_valid", {31'd0, rpt_valid4}, 32'd1);
    chk("sat_lane",  {30'd0, rpt_lane4},  32'd0);
    chk("sat_len",   {28'd0, rpt_len4},   32'd15);
    tick();
    chk("sat_drain", {31'd0, rpt_valid4}, 32'd0);

    // Backpressure: three pulses on lane 2, third one dropped
    rpt_ready = 1'b0;
    rst_in[2] = 1'b1; repeat (4) tick(); rst_in[2] = 1'b0;
    tick();
    chk("min_len_short", {28'd0, err_short}, 32'h0);
    tick();
    chk_rpt("bp1", 1, 2, 4);
    rst_in[2] = 1'b1; repeat (5) tick(); rst_in[2] = 1'b0;
    tick();
    chk("bp2_ovf", {28'd0, err_ovf}, 32'h0);
    rst_in[2] = 1'b1; repeat (6) tick(); rst_in[2] = 1'b0;
    tick();
    chk("bp3_ovf", {28'd0, err_ovf}, 32'h4);
    chk_rpt("bp_hold", 1, 2, 4);
    rpt_ready = 1'b1;
    tick();
    chk_rpt("bp2", 1, 2, 5);
    tick();
    chk("bp_drain", {31'd0, rpt_valid}, 32'd0);
    chk("bp_ovf_sticky", {28'd0, err_ovf}, 32'h4);

    // Monitor reset mid-pulse and mid-backpressure
    rpt_ready = 1'b0;
    rst_in[0] = 1'b1; repeat (5) tick();
    rst_in[0] = 1'b0; rst_in[1] = 1'b1;
    tick(); tick();
    chk_rpt("pre_rst", 1, 0, 5);
    chk("pre_rst_active", {28'd0, lane_active}, 32'h2);
    rst = 1'b1;
    tick();
    chk_rpt("mid_rst", 0, 0, 0);
    chk("mid_rst_active", {28'd0, lane_active}, 32'h0);
    chk("mid_rst_ovf", {28'd0, err_ovf}, 32'h0);
    rst = 1'b0;
    tick();
    chk("sync_hold", {28'd0, lane_active}, 32'h0);
    rst_in[1] = 1'b0;
    tick();
    rpt_ready = 1'b1;
    tick(); tick();
    chk("no_stale", {31'd0, rpt_valid}, 32'd0);

    // Lane 3 high across reset release is never reported
    rst_in[3] = 1'b1; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (19) tick();
    chk("sync_active", {28'd0, lane_active}, 32'h0);
    rst_in[3] = 1'b0;
    tick(); tick();
    chk("sync_norpt", {31'd0, rpt_valid}, 32'd0);
    rst_in[3] = 1'b1; repeat (6) tick(); rst_in[3] = 1'b0;
    tick(); tick();
    chk_rpt("after_sync", 1, 3, 6);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_rst_mon.md
# clk_rst_mon

Receive-side companion to the clock/reset generator. Samples the FANOUT reset lines delivered to the design on the shared clock, measures each completed reset pulse in clock cycles, flags runt pulses and dropped reports, and streams per-pulse reports out through a valid/ready port. It sits at the consuming end of the clk_rst fanout and gives the design and bench a checked, cycle-accurate record of every reset it actually received.

## Interface
- FANOUT, proj_param_pkg::PROJ_CLK_RST_FANOUT (4 in standalone builds): number of monitored reset lanes, ≥1
- MIN_PULSE, 4: minimum legal pulse length in cycles, ≥1
- CNT_W, 16: pulse-length counter width
- LANE_W, $clog2(FANOUT) (min 1): lane index width
- clk  in  1  single clock; all inputs synchronous to it
- rst  in  1  monitor's own reset, synchronous, active-high
- rst_in  in  FANOUT  monitored reset lanes, active-high, already synchronous to clk
- lane_active  out  FANOUT  lane currently inside a measured pulse
- err_short  out  FANOUT  sticky: a pulse shorter than MIN_PULSE completed
- err_ovf  out  FANOUT  sticky: a report was dropped because the lane's pending slot was full
- err_clr  in  1  clears all sticky error bits
- rpt_valid  out  1  report available
- rpt_ready  in  1  consumer accepts report
- rpt_lane  out  LANE_W  lane of the report
- rpt_len  out  CNT_W  pulse length in cycles (saturated)

## Operation
- Per lane FSM: SYNC → IDLE → ACTIVE → IDLE …
  - SYNC (after rst): ignore lane until rst_in sampled low, then IDLE. A pulse already in progress at monitor reset is never reported.
  - IDLE: rst_in sampled high → ACTIVE, cnt=1.
  - ACTIVE: rst_in high → cnt+1, saturating at 2^CNT_W−1. rst_in low → IDLE, complete pulse with len=cnt.
- Pulse completion: if len<MIN_PULSE set err_short[lane]. Load len into lane's single pending slot. If the slot is full and not being drained this edge, keep the old value, drop the new one, and set err_ovf[lane].
- Output register (one entry): loaded when empty or when rpt_valid&&rpt_ready at this edge. Source is a round-robin choice among full pending slots, starting after the last granted lane. The granted slot frees on the same edge.
- Pending slot drained and refilled on the same edge: the new pulse is stored and no overflow is flagged.
- err_clr clears all sticky bits. A set event on the same edge wins for that bit.
- lane_active = (state==ACTIVE).

## Timing
- rst (sync): all lanes SYNC, cnt=0, pending empty, RR pointer=0. Outputs: lane_active=0, err_short=0, err_ovf=0, rpt_valid=0, rpt_lane=0, rpt_len=0. Takes effect at the first edge rst is sampled high. In-flight report and pending data are discarded.
- Edge k samples rst_in high in IDLE: lane_active=1 after edge k.
- Edge k samples rst_in low in ACTIVE: lane_active=0, pending loaded, and err_short updated after edge k. Output register loads at edge k+1 if free, so rpt_valid rises 1 cycle after lane_active falls.
- A pulse of N high samples reports rpt_len=N.
- rpt_valid/lane/len stay stable while rpt_valid&&!rpt_ready. Back-to-back acceptance sustains 1 report/cycle.
- Minimum measurable pulse: 1 cycle. Back-to-back pulses need ≥1 low sample between them.

## Test plan
- Single lane, rst_in[0] high 10 cycles after monitor reset, rpt_ready=1 → one report lane=0 len=10, rpt_valid 1 cycle after lane_active[0] falls, no errors.
- rst_in[1] high 2 cycles (MIN_PULSE=4) → report len=2, err_short[1]=1 sticky; pulse err_clr → 0. err_clr coincident with a new runt → bit stays 1.
- All 4 lanes fall on the same edge with lengths 5,6,7,8, rpt_ready=1 → reports in lane order 0,1,2,3 on consecutive cycles. Repeat with pointer after lane 1 → order 2,3,0,1.
- rpt_ready=0, lane 2 completes three pulses → first in output register, second pending, third dropped with err_ovf[2]=1. Raise ready → two reports with lengths of pulses 1 and 2.
- rst_in[3] high across monitor reset release, falls after 20 cycles → no report (SYNC). Next 6-cycle pulse → len=6.
- CNT_W=4, 20-cycle pulse → rpt_len=15. Monitor rst mid-pulse and mid-backpressure → all outputs 0 next cycle, no stale report.
